// File: rtl/regfile_seq_ctrl_if.sv
// Handshake and register-file control bundle between
// the instruction decoder and regfile_seq_ctrl.
interface regfile_seq_ctrl_if;
    logic       start;
    logic [1:0] cls;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       alu_done;
    logic       mem_ready;
    logic [3:0] RA;
    logic [3:0] RB;
    logic [3:0] RWD;
    logic       RegWr1;
    logic       RegWr2;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] phase;

    modport master (
        output start, cls, rd, rs1, rs2,
        output alu_done, mem_ready,
        input  RA, RB, RWD, RegWr1, RegWr2,
        input  busy, done, err, phase
    );

    modport slave (
        input  start, cls, rd, rs1, rs2,
        input  alu_done, mem_ready,
        output RA, RB, RWD, RegWr1, RegWr2,
        output busy, done, err, phase
    );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Multi-cycle sequencer driving the two-write-port
// register file addresses and write enables.
module regfile_seq_ctrl #(
    parameter int TIMEOUT     = 16,
    parameter bit R0_WRITABLE = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    regfile_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FIN    = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [1:0] C_ALU   = 2'd0;
    localparam logic [1:0] C_STORE = 2'd2;
    localparam logic [1:0] C_LDINC = 2'd3;
    localparam logic [7:0] LIMIT   = 8'(TIMEOUT);

    state_t     state;
    logic [1:0] cls_q;
    logic [7:0] cnt;
    logic       wr1_ok;
    logic       wr2_ok;

    // RWD/RA already hold the latched rd/rs1 fields
    assign wr1_ok = (bus.RWD != 4'd0) || R0_WRITABLE;
    assign wr2_ok = (cls_q == C_LDINC) &&
                    ((bus.RA != 4'd0) || R0_WRITABLE);

    assign bus.phase = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cls_q      <= 2'd0;
            cnt        <= 8'd0;
            bus.RA     <= 4'd0;
            bus.RB     <= 4'd0;
            bus.RWD    <= 4'd0;
            bus.RegWr1 <= 1'b0;
            bus.RegWr2 <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
            bus.RegWr1 <= 1'b0;
            bus.RegWr2 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= DECODE;
                        bus.busy <= 1'b1;
                        cls_q    <= bus.cls;
                        bus.RA   <= bus.rs1;
                        bus.RB   <= bus.rs2;
                        bus.RWD  <= bus.rd;
                    end
                end
                DECODE: begin
                    state <= EXEC;
                    cnt   <= 8'd0;
                end
                EXEC: begin
                    if (bus.alu_done) begin
                        cnt <= 8'd0;
                        if (cls_q == C_ALU) begin
                            state      <= WB;
                            bus.RegWr1 <= wr1_ok;
                        end else begin
                            state <= MEM;
                        end
                    end else if (cnt == LIMIT) begin
                        state   <= ERR;
                        bus.done <= 1'b1;
                        bus.err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        if (cls_q == C_STORE) begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                        end else begin
                            state      <= WB;
                            bus.RegWr1 <= wr1_ok;
                            bus.RegWr2 <= wr2_ok;
                        end
                    end else if (cnt == LIMIT) begin
                        state    <= ERR;
                        bus.done <= 1'b1;
                        bus.err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WB: begin
                    state    <= FIN;
                    bus.done <= 1'b1;
                end
                FIN, ERR: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Randomised self-checking bench for regfile_seq_ctrl;
// a timeline model predicts every cycle of each instruction.
module tb_regfile_seq_ctrl;
    localparam int TO = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    regfile_seq_ctrl_if if0 ();
    regfile_seq_ctrl_if if1 ();

    assign if1.start     = if0.start;
    assign if1.cls       = if0.cls;
    assign if1.rd        = if0.rd;
    assign if1.rs1       = if0.rs1;
    assign if1.rs2       = if0.rs2;
    assign if1.alu_done  = if0.alu_done;
    assign if1.mem_ready = if0.mem_ready;

    regfile_seq_ctrl #(.TIMEOUT(TO), .R0_WRITABLE(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    regfile_seq_ctrl #(.TIMEOUT(TO), .R0_WRITABLE(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_zero(input string name);
        logic [20:0] g0;
        logic [20:0] g1;
        g0 = {if0.RA, if0.RB, if0.RWD, if0.RegWr1, if0.RegWr2,
              if0.busy, if0.done, if0.err, if0.phase};
        g1 = {if1.RA, if1.RB, if1.RWD, if1.RegWr1, if1.RegWr2,
              if1.busy, if1.done, if1.err, if1.phase};
        tests++;
        if (g0 !== 21'd0 || g1 !== 21'd0) begin
            fails++;
            $display("FAIL %s outputs got %h/%h exp 0", name, g0, g1);
        end
    endtask

    // a/m: cycles the ALU/memory handshake stays low after
    // the phase is entered; a value above TO never arrives.
    task automatic run_instr(input string name,
                             input logic [1:0] c_cls,
                             input logic [3:0] c_rd,
                             input logic [3:0] c_rs1,
                             input logic [3:0] c_rs2,
                             input int a,
                             input int m,
                             input bit poke);
        bit ex_to;
        bit mem_to;
        bit is_err;
        int exec_end;
        int mem_end;
        int done_c;
        int wb_c;
        int c;
        logic [2:0] ph;
        logic [7:0] exp0;
        logic [7:0] got0;
        logic [2:0] exp1;
        logic [2:0] got1;
        logic [11:0] fexp;
        logic [11:0] fgot;

        ex_to    = a > TO;
        mem_to   = !ex_to && c_cls != 2'd0 && m > TO;
        is_err   = ex_to || mem_to;
        exec_end = 2 + (ex_to ? TO : a);
        mem_end  = exec_end + 1 + (mem_to ? TO : m);
        if (ex_to)              done_c = exec_end + 1;
        else if (c_cls == 2'd0) done_c = exec_end + 2;
        else if (mem_to)        done_c = mem_end + 1;
        else if (c_cls == 2'd2) done_c = mem_end + 1;
        else                    done_c = mem_end + 2;
        wb_c = (is_err || c_cls == 2'd2) ? -1 : done_c - 1;
        fexp = {c_rs1, c_rs2, c_rd};

        if0.cls = c_cls;
        if0.rd  = c_rd;
        if0.rs1 = c_rs1;
        if0.rs2 = c_rs2;
        for (int cyc = 0; cyc <= done_c; cyc++) begin
            if0.start = (cyc == 0) || (poke && cyc == 2);
            if (poke && cyc == 2) begin
                if0.cls = 2'($urandom);
                if0.rd  = 4'($urandom);
                if0.rs1 = 4'($urandom);
                if0.rs2 = 4'($urandom);
            end
            if0.alu_done = (!ex_to && cyc >= 2 + a) ||
                           (cyc < 2 && $urandom_range(0, 1) == 1);
            if0.mem_ready = (!mem_to && cyc >= 3 + a + m) ||
                            (cyc < 3 + a &&
                             $urandom_range(0, 1) == 1);
            @(posedge clk);
            #1;
            c = cyc + 1;
            if (c > done_c)       ph = 3'd0;
            else if (c == done_c) ph = is_err ? 3'd6 : 3'd5;
            else if (c == wb_c)   ph = 3'd4;
            else if (c == 1)      ph = 3'd1;
            else if (c <= exec_end) ph = 3'd2;
            else                  ph = 3'd3;
            exp0 = {c <= done_c, c == done_c,
                    c == done_c && is_err,
                    c == wb_c && c_rd != 4'd0,
                    c == wb_c && c_cls == 2'd3 && c_rs1 != 4'd0,
                    ph};
            got0 = {if0.busy, if0.done, if0.err,
                    if0.RegWr1, if0.RegWr2, if0.phase};
            tests++;
            if (got0 !== exp0) begin
                fails++;
                $display("FAIL %s c=%0d status got %b exp %b",
                         name, c, got0, exp0);
            end
            exp1 = {c == wb_c, c == wb_c && c_cls == 2'd3,
                    c == done_c};
            got1 = {if1.RegWr1, if1.RegWr2, if1.done};
            tests++;
            if (got1 !== exp1) begin
                fails++;
                $display("FAIL %s c=%0d r0w got %b exp %b",
                         name, c, got1, exp1);
            end
            fgot = {if0.RA, if0.RB, if0.RWD};
            tests++;
            if (fgot !== fexp) begin
                fails++;
                $display("FAIL %s c=%0d fields got %h exp %h",
                         name, c, fgot, fexp);
            end
        end
        if0.start     = 1'b0;
        if0.alu_done  = 1'b0;
        if0.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_held");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_zero("reset_idle");
    endtask

    task automatic test_alu();
        run_instr("alu", 2'd0, 4'd5, 4'd4, 4'd2, 0, 0, 1'b0);
        run_instr("alu_wait", 2'd0, 4'd9, 4'd1, 4'd3, 3, 0, 1'b0);
    endtask

    task automatic test_ldinc();
        run_instr("ldinc", 2'd3, 4'd3, 4'd6, 4'd0, 0, 3, 1'b0);
        run_instr("ldinc_same", 2'd3, 4'd7, 4'd7, 4'd1, 1, 0, 1'b0);
        run_instr("ldinc_r0", 2'd3, 4'd2, 4'd0, 4'd1, 0, 0, 1'b0);
    endtask

    task automatic test_store();
        run_instr("store", 2'd2, 4'd7, 4'd1, 4'd8, 0, 0, 1'b0);
        run_instr("load", 2'd1, 4'd4, 4'd2, 4'd8, 0, 0, 1'b0);
    endtask

    task automatic test_r0();
        run_instr("r0_alu", 2'd0, 4'd0, 4'd3, 4'd3, 0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_instr("mem_to", 2'd1, 4'd5, 4'd2, 4'd2, 0, TO + 1, 1'b0);
        run_instr("mem_edge", 2'd1, 4'd5, 4'd2, 4'd2, 0, TO, 1'b0);
        run_instr("exec_to", 2'd0, 4'd6, 4'd1, 4'd1, TO + 1, 0, 1'b0);
        run_instr("exec_edge", 2'd3, 4'd6, 4'd1, 4'd1, TO, TO, 1'b0);
    endtask

    task automatic test_busy_poke();
        run_instr("poke", 2'd1, 4'd8, 4'd9, 4'd10, 2, 1, 1'b1);
    endtask

    task automatic test_reset_mid();
        if0.cls      = 2'd3;
        if0.rd       = 4'd11;
        if0.rs1      = 4'd12;
        if0.rs2      = 4'd13;
        if0.start    = 1'b1;
        if0.alu_done = 1'b0;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid");
        if0.alu_done  = 1'b1;
        if0.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_zero("after_reset");
        end
        if0.alu_done  = 1'b0;
        if0.mem_ready = 1'b0;
        run_instr("recover", 2'd1, 4'd1, 4'd2, 4'd3, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_instr("rand", 2'($urandom), 4'($urandom),
                      4'($urandom), 4'($urandom),
                      $urandom_range(0, TO + 2),
                      $urandom_range(0, TO + 2),
                      $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        if0.start     = 1'b0;
        if0.cls       = 2'd0;
        if0.rd        = 4'd0;
        if0.rs1       = 4'd0;
        if0.rs2       = 4'd0;
        if0.alu_done  = 1'b0;
        if0.mem_ready = 1'b0;
        test_reset();
        test_alu();
        test_ldinc();
        test_store();
        test_r0();
        test_timeout();
        test_busy_poke();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_seq_ctrl.md
# regfile_seq_ctrl

Multi-cycle sequencer for the processor's two-write-port register file. It accepts one instruction's register fields and class through a start handshake. It then steps through decode, execute, memory and write-back phases, driving the register file's address and write-enable lines (RA, RB, RWD, RegWr1, RegWr2). It sits between the main instruction decoder and `reg_file`. Write data (WB1/WB2) is supplied by the datapath, not by this block.

## Interface
- TIMEOUT, 16: maximum cycles spent waiting in EXEC or MEM before aborting (range 1..255).
- R0_WRITABLE, 0: when 0, writes addressed to register 0 are suppressed.

- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to execute one instruction; accepted only when busy=0.
- cls  in  2  instruction class: 0=ALU, 1=LOAD, 2=STORE, 3=LDINC (load with base-register increment).
- rd  in  4  destination register.
- rs1  in  4  source/base register.
- rs2  in  4  second source register.
- alu_done  in  1  ALU result valid.
- mem_ready  in  1  memory access complete.
- RA  out  4  register file read address A / RegWr2 target.
- RB  out  4  register file read address B.
- RWD  out  4  register file write address for RegWr1.
- RegWr1  out  1  write enable, WB1 -> reg[RWD].
- RegWr2  out  1  write enable, WB2 -> reg[RA].
- busy  out  1  instruction in flight.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout-abort pulse, coincident with done.
- phase  out  3  current state encoding.

## Operation
- All outputs are registered (Moore). Inputs are sampled on the rising clk edge.
- States and encodings: IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4, FIN=5, ERR=6.
- IDLE: if start=1, latch cls/rd/rs1/rs2, then go to DECODE. Otherwise stay in IDLE.
- DECODE (1 cycle): RA=rs1, RB=rs2, RWD=rd. Next state is EXEC.
- EXEC: wait for alu_done=1. Then ALU goes to WB, and LOAD/STORE/LDINC go to MEM.
- MEM: wait for mem_ready=1. Then STORE goes to FIN, and LOAD/LDINC go to WB.
- WB (1 cycle):
  - RegWr1=1, unless rd=0 and R0_WRITABLE=0.
  - For LDINC only, RegWr2=1, unless rs1=0 and R0_WRITABLE=0.
  - Next state is FIN.
- FIN (1 cycle): done=1, then IDLE.
- ERR (1 cycle): done=1 and err=1, with no register writes, then IDLE.
- Wait counter:
  - 8 bits, cleared on entry to EXEC and on entry to MEM.
  - Increments each cycle the awaited handshake is low.
  - When the count reaches TIMEOUT with the handshake still low, the next state is ERR.
  - The handshake takes priority over timeout in the same cycle.
- LDINC where rd=rs1: both enables assert in WB. The ordering of the two writes is resolved inside reg_file; this block does not arbitrate.
- RA/RB/RWD hold the latched fields from DECODE through FIN/ERR. In IDLE they hold their last values.
- busy=1 in every state except IDLE.
- start while busy=1 is ignored; it is neither queued nor latched.
- alu_done/mem_ready asserted outside EXEC/MEM are ignored.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE, wait counter=0.
  - All outputs 0: RA, RB, RWD, RegWr1, RegWr2, busy, done, err, phase.
  - Reset mid-instruction aborts with no write and no done pulse.
- Latency from start to done, counting the cycle start is sampled as cycle 0, with handshakes already high on entry:
  - ALU: done at cycle 4.
  - STORE: done at cycle 4.
  - LOAD/LDINC: done at cycle 5.
- Each wait cycle in EXEC or MEM adds one cycle of latency.
- RegWr1/RegWr2 are high for exactly one cycle, which is the cycle before done.
- Timeout: ERR is entered TIMEOUT+1 cycles after EXEC/MEM entry when the handshake never arrives.
- start may be reasserted in the cycle after done. The earliest restart is from IDLE, so there is a one-cycle gap between instructions.

## Test plan
- Reset then ALU: cls=0, rd=5, rs1=4, rs2=2, alu_done tied 1 -> RA=4, RB=2, RWD=5 from cycle 1; RegWr1=1, RegWr2=0 at cycle 3; done=1 at cycle 4; busy falls at cycle 5.
- LDINC: cls=3, rd=3, rs1=6, alu_done=1, mem_ready low for 3 cycles -> RegWr1=1 and RegWr2=1 together, RA=6, RWD=3; done at cycle 8.
- STORE: cls=2, rd=7 -> RegWr1 and RegWr2 never assert; done at cycle 4.
- R0 suppression: R0_WRITABLE=0, ALU with rd=0 -> RegWr1 stays 0, done still pulses. With R0_WRITABLE=1, RegWr1=1.
- Timeout: TIMEOUT=4, LOAD with mem_ready held 0 -> ERR at the 5th MEM-wait boundary, done=1 and err=1 for one cycle, no writes, then IDLE. Repeat with mem_ready rising exactly on the timeout cycle -> normal WB, err=0.
- Abuse cases:
  - start pulsed while busy: must be ignored, with fields unchanged.
  - rst_n dropped during WB-1 (EXEC): all outputs 0 immediately, no done pulse.
  - A new instruction after release must complete normally.
